srt_div_controller: RTL and testbench

SRT_DIV_CONTROLLER -- requirements
Module: srt_div_controller

---
 rtl/srt_div_controller_if.sv | 34 +++
 rtl/srt_div_controller.sv | 237 +++++++++++++++++++++++
 tb/tb_srt_div_controller.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/srt_div_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : srt_div_controller_if
// Purpose  : Request/response bundle for the radix-4 SRT divider.
//            The master issues start with the operands. The slave (the
//            divider) returns status and results.
// Signals  : start, dividend, divisor          (master -> slave)
//            busy, done, div_by_zero,
//            quotient, remainder               (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface srt_div_controller_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  start;
   logic [DATA_WIDTH-1:0] dividend;
   logic [DATA_WIDTH-1:0] divisor;
   logic                  busy;
   logic                  done;
   logic                  div_by_zero;
   logic [DATA_WIDTH-1:0] quotient;
   logic [DATA_WIDTH-1:0] remainder;

   modport master (
      output start, dividend, divisor,
      input  busy, done, div_by_zero, quotient, remainder
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, div_by_zero, quotient, remainder
   );
endinterface
`default_nettype wire

// File: rtl/srt_div_controller.sv
`default_nettype none
// ============================================================================
// Module   : srt_radix4_stage / srt_div_controller
// Purpose  : Fixed-latency unsigned divider. It uses one radix-4 SRT stage
//            with digit set {-3..+3}, which is reused once per iteration.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            bus (slave modport)   - start/dividend/divisor in;
//                                    busy/done/div_by_zero/quotient/
//                                    remainder out
// Revision : 1.0 - initial release
// ============================================================================

// One radix-4 step: Y = 4*P + next two dividend bits; choose q in {-3..3}
// from the truncated Y and divisor; P' = Y - q*D; Q' = 4*Q + q.
// The divisor is normalised, so D[MSB] = 1. The invariant -D <= P < D holds.
// The selection picks the largest q whose conservative test passes:
// Yt >= q*Dt for q > 0, and Yt >= q*(Dt+1) for q < 0. These tests keep the
// next remainder inside [-D, D).
module srt_radix4_stage #(
   parameter int DATA_WIDTH = 16
) (
   input  wire logic signed [DATA_WIDTH+2:0]   i_pr,
   input  wire logic        [1:0]              i_bits,
   input  wire logic        [DATA_WIDTH-1:0]   i_divisor,
   input  wire logic signed [2*DATA_WIDTH-1:0] i_q,
   output logic signed      [DATA_WIDTH+2:0]   o_pr,
   output logic signed      [2*DATA_WIDTH-1:0] o_q
);
   localparam int c_pw = DATA_WIDTH + 3;
   localparam int c_qw = 2 * DATA_WIDTH;

   logic signed [c_pw-1:0] w_y;
   logic signed [c_pw-1:0] w_d_ext;
   logic signed [c_pw-1:0] w_qd;
   logic signed [8:0]      w_yt;
   logic signed [8:0]      w_dt;
   logic signed [8:0]      w_dt1;
   logic        [2:0]      w_digit;   // two's complement digit

   assign w_y     = (i_pr <<< 2) + $signed({{(c_pw-2){1'b0}}, i_bits});
   assign w_yt    = {{2{w_y[c_pw-1]}}, w_y[c_pw-1:DATA_WIDTH-4]};
   assign w_dt    = {5'b00000, i_divisor[DATA_WIDTH-1:DATA_WIDTH-4]};
   assign w_dt1   = w_dt + 9'sd1;
   assign w_d_ext = $signed({3'b000, i_divisor});

   always_comb begin
      if (w_yt >= 9'sd3 * w_dt)             w_digit = 3'b011;
      else if (w_yt >= 9'sd2 * w_dt)        w_digit = 3'b010;
      else if (w_yt >= w_dt)                w_digit = 3'b001;
      else if (w_yt >= 9'sd0)               w_digit = 3'b000;
      else if (w_yt >= -w_dt1)              w_digit = 3'b111;
      else if (w_yt >= -(9'sd2 * w_dt1))    w_digit = 3'b110;
      else                                  w_digit = 3'b101;
   end

   always_comb begin
      w_qd = '0;
      case (w_digit)
         3'b001:  w_qd = w_d_ext;
         3'b010:  w_qd = w_d_ext <<< 1;
         3'b011:  w_qd = w_d_ext + (w_d_ext <<< 1);
         3'b111:  w_qd = -w_d_ext;
         3'b110:  w_qd = -(w_d_ext <<< 1);
         3'b101:  w_qd = -(w_d_ext + (w_d_ext <<< 1));
         default: w_qd = '0;
      endcase
   end

   assign o_pr = w_y - w_qd;
   assign o_q  = (i_q <<< 2) + $signed({{(c_qw-3){w_digit[2]}}, w_digit});
endmodule

module srt_div_controller #(
   parameter int DATA_WIDTH = 16
) (
   input  wire logic           clk,
   input  wire logic           reset,
   srt_div_controller_if.slave bus
);
   localparam int c_pw = DATA_WIDTH + 3;
   localparam int c_qw = 2 * DATA_WIDTH;
   localparam int c_sw = $clog2(DATA_WIDTH);
   localparam int c_cw = (DATA_WIDTH/2 > 1) ? $clog2(DATA_WIDTH/2) : 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      NORM = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;
   logic                    w_accept;
   logic                    w_busy;
   logic                    w_done;

   logic [DATA_WIDTH-1:0]   r_dividend;   // low aligned dividend bits after NORM
   logic [DATA_WIDTH-1:0]   r_divisor;    // normalised divisor after NORM
   logic [c_sw-1:0]         r_shift;
   logic [c_cw-1:0]         r_count;
   logic signed [c_pw-1:0]  r_pr;
   logic signed [c_qw-1:0]  r_q;
   logic [DATA_WIDTH-1:0]   r_quotient;
   logic [DATA_WIDTH-1:0]   r_remainder;
   logic                    r_dbz;

   logic [c_sw-1:0]         w_shift;
   logic [c_qw-1:0]         w_x_aligned;
   logic [DATA_WIDTH-1:0]   w_d_norm;
   logic signed [c_pw-1:0]  w_pr_next;
   logic signed [c_qw-1:0]  w_q_next;
   logic signed [c_pw-1:0]  w_pr_fixed;
   logic signed [c_qw-1:0]  w_q_fixed;

   // Leading-zero count of the latched divisor. The highest set bit wins.
   always_comb begin
      w_shift = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (r_divisor[i]) w_shift = c_sw'(DATA_WIDTH - 1 - i);
      end
   end

   // Because D >= 2^(W-1), the upper half of the aligned dividend is below D.
   // It seeds the partial remainder. The lower half is fed in two bits per
   // iteration.
   assign w_x_aligned = {{DATA_WIDTH{1'b0}}, r_dividend} << w_shift;
   assign w_d_norm    = r_divisor << w_shift;

   srt_radix4_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
      .i_pr      (r_pr),
      .i_bits    (r_dividend[DATA_WIDTH-1:DATA_WIDTH-2]),
      .i_divisor (r_divisor),
      .i_q       (r_q),
      .o_pr      (w_pr_next),
      .o_q       (w_q_next)
   );

   assign w_pr_fixed = r_pr[c_pw-1] ? r_pr + $signed({3'b000, r_divisor}) : r_pr;
   assign w_q_fixed  = r_pr[c_pw-1] ? r_q - c_qw'(1) : r_q;

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_accept     = 1'b1;
               w_next_state = (bus.divisor == '0) ? DONE : NORM;
            end
         end
         NORM: begin
            w_busy       = 1'b1;
            w_next_state = ITER;
         end
         ITER: begin
            w_busy = 1'b1;
            if (r_count == c_cw'(DATA_WIDTH/2 - 1)) w_next_state = FIX;
         end
         FIX: begin
            w_busy       = 1'b1;
            w_next_state = DONE;
         end
         DONE: begin
            w_done       = 1'b1;
            w_next_state = IDLE;
            if (bus.start) begin
               w_accept     = 1'b1;
               w_next_state = (bus.divisor == '0) ? DONE : NORM;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dividend  <= '0;
         r_divisor   <= '0;
         r_shift     <= '0;
         r_count     <= '0;
         r_pr        <= '0;
         r_q         <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else if (w_accept) begin
         r_dividend <= bus.dividend;
         r_divisor  <= bus.divisor;
         if (bus.divisor == '0) begin
            r_quotient  <= '1;
            r_remainder <= bus.dividend;
            r_dbz       <= 1'b1;
         end
      end else begin
         case (r_state)
            NORM: begin
               r_divisor  <= w_d_norm;
               r_shift    <= w_shift;
               r_dividend <= w_x_aligned[DATA_WIDTH-1:0];
               r_pr       <= $signed({3'b000, w_x_aligned[c_qw-1:DATA_WIDTH]});
               r_q        <= '0;
               r_count    <= '0;
            end
            ITER: begin
               r_pr       <= w_pr_next;
               r_q        <= w_q_next;
               r_dividend <= {r_dividend[DATA_WIDTH-3:0], 2'b00};
               r_count    <= r_count + c_cw'(1);
            end
            FIX: begin
               r_pr        <= w_pr_fixed;
               r_q         <= w_q_fixed;
               r_quotient  <= w_q_fixed[DATA_WIDTH-1:0];
               r_remainder <= DATA_WIDTH'(w_pr_fixed >> r_shift);
               r_dbz       <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = w_busy;
   assign bus.done        = w_done;
   assign bus.div_by_zero = r_dbz;
   assign bus.quotient    = r_quotient;
   assign bus.remainder   = r_remainder;
endmodule
`default_nettype wire

// File: tb/tb_srt_div_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_srt_div_controller
// Purpose  : Self-checking bench for srt_div_controller (DATA_WIDTH = 16).
//            It runs directed scenarios, then random operands checked against
//            plain integer division.
// Revision : 1.0 - initial release
// ============================================================================
module tb_srt_div_controller;
   localparam int c_dw  = 16;
   localparam int c_lat = c_dw/2 + 2;   // edges after the accepting edge until done

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   srt_div_controller_if #(.DATA_WIDTH(c_dw)) bus ();

   srt_div_controller #(.DATA_WIDTH(c_dw)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start is held for one edge. The operand pins are then scrambled so that
   // any late sampling of them would corrupt the result.
   task automatic pulse_start(input logic [c_dw-1:0] a, input logic [c_dw-1:0] b);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      tick();
      bus.start    = 1'b0;
      bus.dividend = c_dw'($urandom);
      bus.divisor  = c_dw'($urandom);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (bus.done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic ref_div(input logic [c_dw-1:0] a, input logic [c_dw-1:0] b,
                          output logic [c_dw-1:0] q, output logic [c_dw-1:0] r,
                          output logic dbz);
      if (b == 0) begin
         q = '1; r = a; dbz = 1'b1;
      end else begin
         q = a / b; r = a % b; dbz = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
      tick(); tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
      checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b want=0", bus.div_by_zero); end
      checks++; if (bus.quotient !== 16'h0) begin errors++; $display("FAIL reset_quot got=%h want=0", bus.quotient); end
      checks++; if (bus.remainder !== 16'h0) begin errors++; $display("FAIL reset_rem got=%h want=0", bus.remainder); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int n;
      pulse_start(16'd1000, 16'd7);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b want=1", bus.busy); end
      wait_done(n);
      checks++; if (n != c_lat) begin errors++; $display("FAIL basic_latency got=%0d want=%0d", n, c_lat); end
      checks++; if (bus.quotient !== 16'd142) begin errors++; $display("FAIL basic_quot got=%0d want=142", bus.quotient); end
      checks++; if (bus.remainder !== 16'd6) begin errors++; $display("FAIL basic_rem got=%0d want=6", bus.remainder); end
      checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got=%b want=0", bus.div_by_zero); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got=%b want=0", bus.busy); end
      tick();
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b want=0", bus.done); end
      checks++; if (bus.quotient !== 16'd142 || bus.remainder !== 16'd6) begin
         errors++; $display("FAIL basic_hold got=%0d/%0d want=142/6", bus.quotient, bus.remainder);
      end
   endtask

   task automatic test_extremes();
      logic [c_dw-1:0] tbl_a [2] = '{16'hFFFF, 16'd3};
      logic [c_dw-1:0] tbl_b [2] = '{16'd1, 16'd10};
      logic [c_dw-1:0] tbl_q [2] = '{16'hFFFF, 16'd0};
      logic [c_dw-1:0] tbl_r [2] = '{16'd0, 16'd3};
      int n;
      for (int i = 0; i < 2; i++) begin
         pulse_start(tbl_a[i], tbl_b[i]);
         wait_done(n);
         checks++; if (n != c_lat) begin errors++; $display("FAIL extreme%0d_latency got=%0d want=%0d", i, n, c_lat); end
         checks++; if (bus.quotient !== tbl_q[i]) begin errors++; $display("FAIL extreme%0d_quot got=%h want=%h", i, bus.quotient, tbl_q[i]); end
         checks++; if (bus.remainder !== tbl_r[i]) begin errors++; $display("FAIL extreme%0d_rem got=%h want=%h", i, bus.remainder, tbl_r[i]); end
         tick();
      end
   endtask

   task automatic test_div_zero();
      int n;
      pulse_start(16'd5, 16'd0);
      wait_done(n);
      checks++; if (n != 0) begin errors++; $display("FAIL dz_latency got=%0d want=0", n); end
      checks++; if (bus.quotient !== 16'hFFFF) begin errors++; $display("FAIL dz_quot got=%h want=ffff", bus.quotient); end
      checks++; if (bus.remainder !== 16'd5) begin errors++; $display("FAIL dz_rem got=%0d want=5", bus.remainder); end
      checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b want=1", bus.div_by_zero); end
      tick();
      checks++; if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b1) begin
         errors++; $display("FAIL dz_hold got done=%b dbz=%b want done=0 dbz=1", bus.done, bus.div_by_zero);
      end
   endtask

   task automatic test_start_ignored();
      int n;
      pulse_start(16'd1000, 16'd7);
      tick(); tick(); tick();          // now in ITER
      pulse_start(16'd9, 16'd3);       // must be ignored
      wait_done(n);
      checks++; if (n + 4 != c_lat) begin errors++; $display("FAIL ignore_latency got=%0d want=%0d", n + 4, c_lat); end
      checks++; if (bus.quotient !== 16'd142 || bus.remainder !== 16'd6) begin
         errors++; $display("FAIL ignore_result got=%0d/%0d want=142/6", bus.quotient, bus.remainder);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int n;
      pulse_start(16'd1000, 16'd7);
      wait_done(n);
      checks++; if (bus.quotient !== 16'd142) begin errors++; $display("FAIL b2b_first got=%0d want=142", bus.quotient); end
      pulse_start(16'd50000, 16'd123); // issued in the done cycle
      wait_done(n);
      checks++; if (n != c_lat) begin errors++; $display("FAIL b2b_latency got=%0d want=%0d", n, c_lat); end
      checks++; if (bus.quotient !== 16'd406) begin errors++; $display("FAIL b2b_quot got=%0d want=406", bus.quotient); end
      checks++; if (bus.remainder !== 16'd62) begin errors++; $display("FAIL b2b_rem got=%0d want=62", bus.remainder); end
      tick();
   endtask

   task automatic test_reset_abort();
      bit seen_done = 1'b0;
      pulse_start(16'd1000, 16'd7);
      tick(); tick(); tick();
      reset = 1'b1;
      tick();                          // reset sampled 4 edges after the start edge
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b want=0", bus.done); end
      checks++; if (bus.quotient !== 16'h0 || bus.remainder !== 16'h0 || bus.div_by_zero !== 1'b0) begin
         errors++; $display("FAIL abort_outputs got=%h/%h/%b want=0/0/0", bus.quotient, bus.remainder, bus.div_by_zero);
      end
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.done === 1'b1) seen_done = 1'b1;
      end
      checks++; if (seen_done) begin errors++; $display("FAIL abort_no_done got=1 want=0"); end
   endtask

   task automatic gen_op(output logic [c_dw-1:0] a, output logic [c_dw-1:0] b);
      int sel;
      sel = int'($urandom_range(0, 9));
      a = c_dw'($urandom);
      if (sel < 4) begin
         b = '0;
      end else if (sel < 6) begin
         a = c_dw'($urandom_range(0, 65534));
         b = c_dw'($urandom_range(32'(a) + 1, 65535));
      end else if (sel < 7) begin
         b = c_dw'($urandom_range(1, 15));
      end else begin
         b = c_dw'($urandom_range(1, 65535));
      end
   endtask

   task automatic test_random();
      logic [c_dw-1:0] a, b, eq, er;
      logic            edbz;
      int              n, exp_lat;
      gen_op(a, b);
      pulse_start(a, b);
      for (int i = 0; i < 10000; i++) begin
         wait_done(n);
         ref_div(a, b, eq, er, edbz);
         exp_lat = (b == 0) ? 0 : c_lat;
         checks++;
         if (n != exp_lat) begin
            errors++; $display("FAIL rand_latency #%0d %0d/%0d got=%0d want=%0d", i, a, b, n, exp_lat);
            if (n >= 40) break;
         end
         checks++;
         if (bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== edbz) begin
            errors++;
            $display("FAIL rand_result #%0d %0d/%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                     i, a, b, bus.quotient, bus.remainder, bus.div_by_zero, eq, er, edbz);
         end
         if (i < 9999) begin
            gen_op(a, b);
            pulse_start(a, b);         // accepted in the DONE cycle
         end
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_div_zero();
      test_start_ignored();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
